// File: rtl/vga_pkg.sv
// Shared VGA timing constants and counter sizing helper used by the raster
// timing controller and its counters.
package vga_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low
  localparam int unsigned VGA640_WIDTH  = 640;
  localparam int unsigned VGA640_H_FP   = 16;
  localparam int unsigned VGA640_H_PW   = 96;
  localparam int unsigned VGA640_H_BP   = 48;
  localparam int unsigned VGA640_HEIGHT = 480;
  localparam int unsigned VGA640_V_FP   = 10;
  localparam int unsigned VGA640_V_PW   = 2;
  localparam int unsigned VGA640_V_BP   = 33;
  localparam bit          VGA640_HS_POL = 1'b0;
  localparam bit          VGA640_VS_POL = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high
  localparam int unsigned SVGA800_WIDTH  = 800;
  localparam int unsigned SVGA800_H_FP   = 40;
  localparam int unsigned SVGA800_H_PW   = 128;
  localparam int unsigned SVGA800_H_BP   = 88;
  localparam int unsigned SVGA800_HEIGHT = 600;
  localparam int unsigned SVGA800_V_FP   = 1;
  localparam int unsigned SVGA800_V_PW   = 4;
  localparam int unsigned SVGA800_V_BP   = 23;
  localparam bit          SVGA800_HS_POL = 1'b1;
  localparam bit          SVGA800_VS_POL = 1'b1;

  // Bits needed to count 0..total-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Video timing bundle from the raster timing controller to the pixel source
// and colour mux. All members are registered and change together.
interface vga_timing_ctrl_if #(
  parameter int unsigned N_W = 10,
  parameter int unsigned N_H = 10
);
  logic           oHS;
  logic           oVS;
  logic           oDE;
  logic           oSOF;
  logic           oEOL;
  logic [N_W-1:0] oCountH;
  logic [N_H-1:0] oCountV;

  // No handshake: the sink samples every member on pixel-enabled edges only.
  modport master (output oHS, oVS, oDE, oSOF, oEOL, oCountH, oCountV);
  modport slave  (input  oHS, oVS, oDE, oSOF, oEOL, oCountH, oCountV);
endinterface

// File: rtl/wrap_counter.sv
// Modulo-LIM counter that advances on iEn and flags the enabled edge on which
// it wraps back to zero.
module wrap_counter
  import vga_pkg::*;
#(
  parameter int unsigned LIM = 2,
  parameter int unsigned W   = cnt_width(LIM)
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iEn,
  output logic [W-1:0] oQ,
  output logic         oWrap
);

  localparam logic [W-1:0] LAST = W'(LIM - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (iEn) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oQ    = cnt_q;
  assign oWrap = iEn & at_last;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing controller: horizontal/vertical position counters with a
// registered decode stage producing sync, data-enable and frame/line markers.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH  = VGA640_WIDTH,
  parameter int unsigned H_FP   = VGA640_H_FP,
  parameter int unsigned H_PW   = VGA640_H_PW,
  parameter int unsigned H_BP   = VGA640_H_BP,
  parameter int unsigned HEIGHT = VGA640_HEIGHT,
  parameter int unsigned V_FP   = VGA640_V_FP,
  parameter int unsigned V_PW   = VGA640_V_PW,
  parameter int unsigned V_BP   = VGA640_V_BP,
  parameter bit          HS_POL = VGA640_HS_POL,
  parameter bit          VS_POL = VGA640_VS_POL,
  parameter int unsigned N_W    = cnt_width(WIDTH + H_FP + H_PW + H_BP),
  parameter int unsigned N_H    = cnt_width(HEIGHT + V_FP + V_PW + V_BP)
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  vga_timing_ctrl_if.master vid
);

  localparam int unsigned H_TOTAL = WIDTH + H_FP + H_PW + H_BP;
  localparam int unsigned V_TOTAL = HEIGHT + V_FP + V_PW + V_BP;

  generate
    if (WIDTH == 0 || HEIGHT == 0 || H_PW == 0 || V_PW == 0) begin : g_bad_cfg
      $error("vga_timing_ctrl: WIDTH, HEIGHT, H_PW and V_PW must be non-zero");
    end
  endgenerate

  // Inclusive bounds keep every constant below the total, so none overflows N_W/N_H.
  localparam logic [N_W-1:0] H_ACT_LAST   = N_W'(WIDTH - 1);
  localparam logic [N_W-1:0] H_SYNC_FIRST = N_W'(WIDTH + H_FP);
  localparam logic [N_W-1:0] H_SYNC_LAST  = N_W'(WIDTH + H_FP + H_PW - 1);
  localparam logic [N_H-1:0] V_ACT_LAST   = N_H'(HEIGHT - 1);
  localparam logic [N_H-1:0] V_SYNC_FIRST = N_H'(HEIGHT + V_FP);
  localparam logic [N_H-1:0] V_SYNC_LAST  = N_H'(HEIGHT + V_FP + V_PW - 1);

  logic [N_W-1:0] h_cnt;
  logic [N_H-1:0] v_cnt;
  logic           h_wrap;
  logic           v_wrap_unused;

  wrap_counter #(.LIM(H_TOTAL), .W(N_W)) u_h_cnt (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (iEn),
    .oQ    (h_cnt),
    .oWrap (h_wrap)
  );

  // Vertical counter steps only on the enabled edge that ends a line.
  wrap_counter #(.LIM(V_TOTAL), .W(N_H)) u_v_cnt (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (h_wrap),
    .oQ    (v_cnt),
    .oWrap (v_wrap_unused)
  );

  logic           h_act;
  logic           v_act;
  logic           hs_d,  hs_q;
  logic           vs_d,  vs_q;
  logic           de_d,  de_q;
  logic           sof_d, sof_q;
  logic           eol_d, eol_q;
  logic [N_W-1:0] cnt_h_d, cnt_h_q;
  logic [N_H-1:0] cnt_v_d, cnt_v_q;

  always_comb begin
    h_act   = (h_cnt <= H_ACT_LAST);
    v_act   = (v_cnt <= V_ACT_LAST);
    cnt_h_d = h_cnt;
    cnt_v_d = v_cnt;
    de_d    = h_act & v_act;
    hs_d    = ((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST)) ? HS_POL : ~HS_POL;
    vs_d    = ((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST)) ? VS_POL : ~VS_POL;
    sof_d   = (h_cnt == '0) && (v_cnt == '0);
    eol_d   = (h_cnt == H_ACT_LAST) && v_act;
  end

  // Every output shares this register stage, so they stay aligned with each other.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
    end else if (iEn) begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign vid.oHS     = hs_q;
  assign vid.oVS     = vs_q;
  assign vid.oDE     = de_q;
  assign vid.oSOF    = sof_q;
  assign vid.oEOL    = eol_q;
  assign vid.oCountH = cnt_h_q;
  assign vid.oCountV = cnt_v_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a tiny 7x5 raster checked vector by vector from
// hand-written decode tables, plus the default 640x480 timing over two lines.
module tb_vga_timing_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl_if #(.N_W(3),  .N_H(3))  s_if ();
  vga_timing_ctrl_if #(.N_W(10), .N_H(10)) d_if ();

  vga_timing_ctrl #(
    .WIDTH(4), .H_FP(1), .H_PW(1), .H_BP(1),
    .HEIGHT(2), .V_FP(1), .V_PW(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .iClk (clk),
    .iRst (rst_n),
    .iEn  (en),
    .vid  (s_if.master)
  );

  vga_timing_ctrl u_dflt (
    .iClk (clk),
    .iRst (rst_n),
    .iEn  (en),
    .vid  (d_if.master)
  );

  typedef struct {
    bit en;
    int eh;
    int ev;
    bit ehs;
    bit evs;
    bit ede;
    bit esof;
    bit eeol;
  } vec_t;

  localparam int NVEC = 80;
  vec_t vecs[NVEC];

  // Small raster: H_TOTAL=7 (active 0..3, hsync at 5), V_TOTAL=5 (active 0..1, vsync at 3)
  bit s_de_h[7]  = '{1, 1, 1, 1, 0, 0, 0};
  bit s_hs_h[7]  = '{0, 0, 0, 0, 0, 1, 0};
  bit s_eol_h[7] = '{0, 0, 0, 1, 0, 0, 0};
  bit s_de_v[5]  = '{1, 1, 0, 0, 0};
  bit s_vs_v[5]  = '{0, 0, 0, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_small_reset(input string tag);
    chk({tag, " small hs"},  int'(s_if.oHS),     0);
    chk({tag, " small vs"},  int'(s_if.oVS),     0);
    chk({tag, " small de"},  int'(s_if.oDE),     0);
    chk({tag, " small sof"}, int'(s_if.oSOF),    0);
    chk({tag, " small eol"}, int'(s_if.oEOL),    0);
    chk({tag, " small h"},   int'(s_if.oCountH), 0);
    chk({tag, " small v"},   int'(s_if.oCountV), 0);
  endtask

  task automatic chk_dflt_reset(input string tag);
    chk({tag, " dflt hs"},  int'(d_if.oHS),     1);
    chk({tag, " dflt vs"},  int'(d_if.oVS),     1);
    chk({tag, " dflt de"},  int'(d_if.oDE),     0);
    chk({tag, " dflt sof"}, int'(d_if.oSOF),    0);
    chk({tag, " dflt eol"}, int'(d_if.oEOL),    0);
    chk({tag, " dflt h"},   int'(d_if.oCountH), 0);
    chk({tag, " dflt v"},   int'(d_if.oCountV), 0);
  endtask

  initial begin
    int ph, pv;
    int hs_low, hs_bad, vs_bad, de_cnt, eol_cnt, eol_bad, sof_cnt, pos_bad;
    int eh, ev;
    bit live;

    // Vector table: 40 enabled edges (past the 35-edge frame wrap), then 1,0 toggling.
    ph = 0; pv = 0; live = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].en = (i < 40) ? 1'b1 : ((i % 2) == 0);
      if (vecs[i].en) begin
        if (!live) begin
          live = 1'b1;
        end else if (ph == 6) begin
          ph = 0;
          pv = (pv == 4) ? 0 : pv + 1;
        end else begin
          ph++;
        end
      end
      vecs[i].eh   = ph;
      vecs[i].ev   = pv;
      vecs[i].ehs  = s_hs_h[ph];
      vecs[i].evs  = s_vs_v[pv];
      vecs[i].ede  = s_de_h[ph] & s_de_v[pv];
      vecs[i].esof = (ph == 0) && (pv == 0);
      vecs[i].eeol = s_eol_h[ph] & s_de_v[pv];
    end

    // Reset held with the enable running: outputs stay at reset values.
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_small_reset("hold");
    chk_dflt_reset("hold");
    en    = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      en = vecs[i].en;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d h", i),   int'(s_if.oCountH), vecs[i].eh);
      chk($sformatf("vec%0d v", i),   int'(s_if.oCountV), vecs[i].ev);
      chk($sformatf("vec%0d hs", i),  int'(s_if.oHS),     int'(vecs[i].ehs));
      chk($sformatf("vec%0d vs", i),  int'(s_if.oVS),     int'(vecs[i].evs));
      chk($sformatf("vec%0d de", i),  int'(s_if.oDE),     int'(vecs[i].ede));
      chk($sformatf("vec%0d sof", i), int'(s_if.oSOF),    int'(vecs[i].esof));
      chk($sformatf("vec%0d eol", i), int'(s_if.oEOL),    int'(vecs[i].eeol));
    end

    // Mid-frame reset between clock edges must clear outputs without a clock.
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_small_reset("async");
    chk_dflt_reset("async");
    en = 1'b1;
    @(posedge clk);
    #1;
    chk_small_reset("async held");
    @(negedge clk);
    rst_n = 1'b1;

    // Default timing: two full lines plus 300 pixels of the third.
    hs_low = 0; hs_bad = 0; vs_bad = 0; de_cnt = 0;
    eol_cnt = 0; eol_bad = 0; sof_cnt = 0; pos_bad = 0;
    for (int n = 0; n < 1901; n++) begin
      @(posedge clk);
      #1;
      eh = n % 800;
      ev = n / 800;
      if (n == 0) begin
        chk("first edge dflt sof", int'(d_if.oSOF),    1);
        chk("first edge dflt de",  int'(d_if.oDE),     1);
        chk("first edge dflt h",   int'(d_if.oCountH), 0);
        chk("first edge small sof", int'(s_if.oSOF),   1);
        chk("first edge small de",  int'(s_if.oDE),    1);
      end
      if (int'(d_if.oCountH) != eh || int'(d_if.oCountV) != ev) pos_bad++;
      if (d_if.oHS == 1'b0) hs_low++;
      if (int'(d_if.oHS) != ((eh >= 656 && eh <= 751) ? 0 : 1)) hs_bad++;
      if (d_if.oVS != 1'b1) vs_bad++;
      if (d_if.oDE) de_cnt++;
      if (d_if.oSOF) sof_cnt++;
      if (d_if.oEOL) begin
        eol_cnt++;
        if (eh != 639) eol_bad++;
      end
    end
    chk("dflt position errors", pos_bad, 0);
    chk("dflt hs low cycles", hs_low, 192);
    chk("dflt hs window errors", hs_bad, 0);
    chk("dflt vs active in active lines", vs_bad, 0);
    chk("dflt de cycles", de_cnt, 2 * 640 + 301);
    chk("dflt sof pulses", sof_cnt, 1);
    chk("dflt eol pulses", eol_cnt, 2);
    chk("dflt eol off position", eol_bad, 0);
    chk("dflt stop h", int'(d_if.oCountH), 300);
    chk("dflt stop v", int'(d_if.oCountV), 2);

    // Reset mid-line, then the frame restarts cleanly at (0,0).
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_dflt_reset("midframe");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart dflt sof", int'(d_if.oSOF),    1);
    chk("restart dflt de",  int'(d_if.oDE),     1);
    chk("restart dflt h",   int'(d_if.oCountH), 0);
    chk("restart dflt v",   int'(d_if.oCountV), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
